// File: rtl/lr_pkg.sv
// ============================================================================
// Module      : lr_pkg
// Description : Shared sizing constants and state encoding for the
//               logistic-regression class scheduler and its MAC unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package lr_pkg;

    localparam int NFEAT      = 81;   // features per window, slot 0 is the bias
    localparam int NCLASS     = 10;   // number of one-vs-all classifiers
    localparam int XW         = 7;    // unsigned pixel width
    localparam int THW        = 32;   // signed theta width
    localparam int ACCW       = 32;   // signed accumulator / score width
    localparam int BIAS_SHIFT = 16;   // bias input is the constant 2^16

    localparam int ADDRW = $clog2(NCLASS * NFEAT);
    localparam int CLSW  = (NCLASS > 1) ? $clog2(NCLASS) : 1;
    localparam int IDXW  = $clog2(NFEAT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        DRAIN = 3'd2,
        CMP   = 3'd3,
        OUT   = 3'd4
    } state_t;

endpackage : lr_pkg

`default_nettype wire

// File: rtl/lr_mac_unit.sv
// ============================================================================
// Module      : lr_mac_unit
// Description : Shared multiply-accumulate for one class score. Each enabled
//               cycle adds either theta<<BIAS_SHIFT (bias slot) or the
//               zero-extended pixel times the signed theta.
//               Optional macro LR_SCORE_SAT_EN: clamp each product and
//               saturate every addition instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lr_mac_unit
    import lr_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   bias_sel,
    input  logic [XW-1:0]          x,
    input  logic signed [THW-1:0]  theta,
    output logic signed [ACCW-1:0] acc
);

    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;
    logic        [ACCW-1:0] base;

`ifdef LR_SCORE_SAT_EN
    // Wide enough to hold either the bias term or the full pixel product.
    localparam int TW = ((XW + 1) > (BIAS_SHIFT + 1) ? (XW + 1) : (BIAS_SHIFT + 1)) + THW;
    localparam logic signed [TW-1:0]   TMAX = {{(TW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
    localparam logic signed [TW-1:0]   TMIN = {{(TW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};
    localparam logic        [ACCW-1:0] AMAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic        [ACCW-1:0] AMIN = {1'b1, {(ACCW-1){1'b0}}};

    logic signed [TW-1:0] theta_ext;
    logic signed [TW-1:0] x_ext;
    logic signed [TW-1:0] term;
    logic        [ACCW-1:0] term_c;
    logic        [ACCW:0]   sum;

    // Exact term, clamped to the score range, then a saturating add.
    always_comb begin
        theta_ext = {{(TW-THW){theta[THW-1]}}, theta};
        x_ext     = {{(TW-XW){1'b0}}, x};
        term      = bias_sel ? (theta_ext <<< BIAS_SHIFT) : (x_ext * theta_ext);
        if (term > TMAX)
            term_c = AMAX;
        else if (term < TMIN)
            term_c = AMIN;
        else
            term_c = term[ACCW-1:0];
        base = clear ? '0 : acc_q;
        sum  = {base[ACCW-1], base} + {term_c[ACCW-1], term_c};
        if (sum[ACCW] != sum[ACCW-1])
            acc_d = sum[ACCW] ? AMIN : AMAX;
        else
            acc_d = sum[ACCW-1:0];
        if (!enable)
            acc_d = acc_q;
    end
`else
    logic [ACCW-1:0] x_n;
    logic [ACCW-1:0] th_n;
    logic [ACCW-1:0] term_n;

    // Modular arithmetic: the low ACCW bits of the product and sum are
    // all that survive truncation, so compute only those.
    always_comb begin
        x_n    = ACCW'(x);
        th_n   = ACCW'(theta);
        term_n = bias_sel ? (th_n << BIAS_SHIFT) : (x_n * th_n);
        base   = clear ? '0 : acc_q;
        acc_d  = enable ? (base + term_n) : acc_q;
    end
`endif

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule : lr_mac_unit

`default_nettype wire

// File: rtl/lr_class_scheduler.sv
// ============================================================================
// Module      : lr_class_scheduler
// Description : Time-multiplexes one MAC unit across all classes, streaming
//               weights from a 1-cycle-latency theta ROM, and returns the
//               argmax class and its score over valid/ready.
//               Optional macro LR_SCORE_SAT_EN (handled in lr_mac_unit).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lr_class_scheduler
    import lr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  win_valid,
    output logic                  win_ready,
    input  logic [NFEAT*XW-1:0]   win_data,
    output logic [ADDRW-1:0]      theta_addr,
    input  logic [THW-1:0]        theta_rdata,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CLSW-1:0]       res_class,
    output logic [ACCW-1:0]       res_score,
    output logic                  busy
);

    state_t                 state_q, state_d;
    logic [CLSW-1:0]        cls_q, cls_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [NFEAT*XW-1:0]    win_q, win_d;

    // MAC controls are registered so they line up with the ROM word that
    // arrives one cycle after its address.
    logic                   mac_en_q, mac_en_d;
    logic                   mac_clr_q, mac_clr_d;
    logic                   mac_bias_q, mac_bias_d;
    logic [XW-1:0]          mac_x_q, mac_x_d;

    logic signed [ACCW-1:0] best_score_q, best_score_d;
    logic [CLSW-1:0]        best_cls_q, best_cls_d;
    logic                   res_valid_q, res_valid_d;
    logic [CLSW-1:0]        res_class_q, res_class_d;
    logic [ACCW-1:0]        res_score_q, res_score_d;

    logic signed [ACCW-1:0] mac_acc;
    logic                   take_new;

    lr_mac_unit u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (mac_clr_q),
        .enable   (mac_en_q),
        .bias_sel (mac_bias_q),
        .x        (mac_x_q),
        .theta    (theta_rdata),
        .acc      (mac_acc)
    );

    // Next-state logic: window capture, feature/class walk, argmax, handoff.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        idx_d        = idx_q;
        win_d        = win_q;
        mac_en_d     = 1'b0;
        mac_clr_d    = 1'b0;
        mac_bias_d   = 1'b0;
        mac_x_d      = win_q[int'(idx_q)*XW +: XW];
        best_score_d = best_score_q;
        best_cls_d   = best_cls_q;
        res_valid_d  = res_valid_q;
        res_class_d  = res_class_q;
        res_score_d  = res_score_q;
        // Class 0 seeds the best; later classes need a strictly larger score.
        take_new     = (cls_q == '0) || (mac_acc > best_score_q);

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    win_d   = win_data;
                    cls_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en_d   = 1'b1;
                mac_clr_d  = (idx_q == '0);
                mac_bias_d = (idx_q == '0);
                if (idx_q == IDXW'(NFEAT-1)) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DRAIN: begin
                state_d = CMP;
            end
            CMP: begin
                if (take_new) begin
                    best_score_d = mac_acc;
                    best_cls_d   = cls_q;
                end
                if (cls_q == CLSW'(NCLASS-1)) begin
                    res_valid_d = 1'b1;
                    res_class_d = take_new ? cls_q : best_cls_q;
                    res_score_d = take_new ? mac_acc : best_score_q;
                    state_d     = OUT;
                end else begin
                    cls_d   = cls_q + CLSW'(1);
                    state_d = MAC;
                end
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial computation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cls_q        <= '0;
            idx_q        <= '0;
            win_q        <= '0;
            mac_en_q     <= 1'b0;
            mac_clr_q    <= 1'b0;
            mac_bias_q   <= 1'b0;
            mac_x_q      <= '0;
            best_score_q <= '0;
            best_cls_q   <= '0;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            res_score_q  <= '0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            idx_q        <= idx_d;
            win_q        <= win_d;
            mac_en_q     <= mac_en_d;
            mac_clr_q    <= mac_clr_d;
            mac_bias_q   <= mac_bias_d;
            mac_x_q      <= mac_x_d;
            best_score_q <= best_score_d;
            best_cls_q   <= best_cls_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            res_score_q  <= res_score_d;
        end
    end

    // ROM address is only driven while walking features; parked at 0 otherwise.
    always_comb begin
        theta_addr = '0;
        if (state_q == MAC)
            theta_addr = ADDRW'(cls_q) * ADDRW'(NFEAT) + ADDRW'(idx_q);
    end

    assign win_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_score = res_score_q;

endmodule : lr_class_scheduler

`default_nettype wire

// File: tb/tb_lr_class_scheduler.sv
// ============================================================================
// Module      : tb_lr_class_scheduler
// Description : Randomized scoreboard bench for lr_class_scheduler with a
//               behavioural ROM and an arithmetic reference model.
//               Honours LR_SCORE_SAT_EN in the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lr_class_scheduler;
    import lr_pkg::*;

    localparam int LAT   = NCLASS * (NFEAT + 2);
    localparam int NWORD = NCLASS * NFEAT;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 win_valid = 1'b0;
    logic                 res_ready = 1'b0;
    logic [NFEAT*XW-1:0]  win_data = '0;
    logic                 win_ready;
    logic                 res_valid;
    logic                 busy;
    logic [ADDRW-1:0]     theta_addr;
    logic [THW-1:0]       theta_rdata = '0;
    logic [CLSW-1:0]      res_class;
    logic [ACCW-1:0]      res_score;

    int rom [NWORD];

    typedef struct {
        int cls;
        int score;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   prev_valid = 1'b0;

    lr_class_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .theta_addr  (theta_addr),
        .theta_rdata (theta_rdata),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_class   (res_class),
        .res_score   (res_score),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous theta ROM: data one cycle after the address.
    always @(posedge clk) begin
        if (int'(theta_addr) < NWORD)
            theta_rdata <= rom[int'(theta_addr)];
        else
            theta_rdata <= '0;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint clamp(input longint v);
        longint hi = 64'sd2147483647;
        longint lo = -64'sd2147483648;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: score = theta[c][0]*65536 + sum x[i]*theta[c][i], argmax with
    // ties to the lowest class.
    function automatic void model(input logic [NFEAT*XW-1:0] w, output int bc, output int bs);
        longint a;
        longint t;
        logic [XW-1:0] xv;
        int s;
        bc = 0;
        bs = 0;
        for (int c = 0; c < NCLASS; c++) begin
            a = 0;
            for (int i = 0; i < NFEAT; i++) begin
                xv = w[i*XW +: XW];
                if (i == 0)
                    t = longint'(rom[c*NFEAT]) * 65536;
                else
                    t = longint'(xv) * longint'(rom[c*NFEAT + i]);
`ifdef LR_SCORE_SAT_EN
                a = clamp(a + clamp(t));
`else
                a = a + t;
`endif
            end
            s = int'(a[31:0]);
            if (c == 0 || s > bs) begin
                bc = c;
                bs = s;
            end
        end
    endfunction

    function automatic logic [NFEAT*XW-1:0] rand_win();
        logic [NFEAT*XW-1:0] w;
        for (int i = 0; i < NFEAT; i++) w[i*XW +: XW] = XW'($urandom);
        return w;
    endfunction

    function automatic logic [NFEAT*XW-1:0] full_win();
        logic [NFEAT*XW-1:0] w;
        for (int i = 0; i < NFEAT; i++) w[i*XW +: XW] = '1;
        return w;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < NWORD; i++) rom[i] = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_win_ready"}, longint'(win_ready), 1);
        check({tag, "_res_valid"}, longint'(res_valid), 0);
        check({tag, "_res_class"}, longint'(res_class), 0);
        check({tag, "_res_score"}, longint'(res_score), 0);
        check({tag, "_busy"},      longint'(busy), 0);
        check({tag, "_theta_addr"}, longint'(theta_addr), 0);
    endtask

    // Monitor: latency on the rising edge of res_valid, values on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (res_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got res_valid=1 expected no result");
                end else begin
                    check("latency", longint'(cyc - sb[0].acc_cyc), LAT);
                end
            end
            if (res_valid && res_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("res_class", longint'(res_class), e.cls);
                check("res_score", longint'(int'(res_score)), e.score);
            end
            prev_valid = res_valid;
        end
    end

    // Offer a window, wait for acceptance, then record its expected result.
    task automatic drive_window(input logic [NFEAT*XW-1:0] w);
        bit   ok = 1'b0;
        exp_t e;
        int   bc, bs;
        win_data  = w;
        win_valid = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (win_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got win_ready=0 expected acceptance");
        end else begin
            model(w, bc, bs);
            e.cls     = bc;
            e.score   = bs;
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        win_data  = rand_win();
    endtask

    // Run res_ready (always-1 or random) until every expected result is out.
    task automatic wait_drain(input bit rnd);
        bit ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !res_valid) begin
                ok = 1'b1;
                break;
            end
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        res_ready = 1'b1;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_txn(input logic [NFEAT*XW-1:0] w, input bit rnd);
        drive_window(w);
        wait_drain(rnd);
    endtask

    initial begin
        bit ok;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;

        // Bias only: class c has bias c, best is the last class.
        clear_rom();
        for (int c = 0; c < NCLASS; c++) rom[c*NFEAT] = c;
        run_txn(rand_win(), 1'b0);

        // All zero weights: full tie resolves to class 0.
        clear_rom();
        run_txn(rand_win(), 1'b1);

        // Only class 3 sees the pixels.
        clear_rom();
        for (int i = 1; i < NFEAT; i++) rom[3*NFEAT + i] = 1;
        run_txn(full_win(), 1'b0);

        // Class 0 overflows its score range.
        clear_rom();
        for (int i = 1; i < NFEAT; i++) rom[i] = 32'sh0100_0000;
        run_txn(full_win(), 1'b0);

        // Full-range random weights.
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NWORD; i++) rom[i] = int'($urandom);
            run_txn(rand_win(), 1'b1);
        end

        // Small weights that make ties likely.
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < NWORD; i++) rom[i] = int'($urandom_range(0, 2)) - 1;
            run_txn((n == 0) ? full_win() : rand_win(), 1'b0);
        end

        // Backpressure: hold the result 50 cycles while a second window waits.
        for (int i = 0; i < NWORD; i++) rom[i] = int'($urandom_range(0, 2000)) - 1000;
        res_ready = 1'b0;
        drive_window(rand_win());
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall_wait: got res_valid=0 expected 1");
        end else begin
            win_data  = rand_win();
            win_valid = 1'b1;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                check("stall_res_valid", longint'(res_valid), 1);
                check("stall_win_ready", longint'(win_ready), 0);
                if (sb.size() > 0) begin
                    check("stall_res_class", longint'(res_class), sb[0].cls);
                    check("stall_res_score", longint'(int'(res_score)), sb[0].score);
                end
            end
            @(posedge clk);
            #1;
            res_ready = 1'b1;
            drive_window(win_data);
        end
        wait_drain(1'b0);

        // Reset in the middle of a computation, then a clean transaction.
        for (int i = 0; i < NWORD; i++) rom[i] = int'($urandom_range(0, 200)) - 100;
        drive_window(rand_win());
        repeat (400) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_res_valid", longint'(res_valid), 0);
        run_txn(rand_win(), 1'b0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lr_class_scheduler

`default_nettype wire
